// File: rtl/pinwheel_bus_port.sv
// pinwheel_bus_port: data-bus slave for the pinwheel core's TileLink port (RAM + posted peripheral FIFO)
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   bus_tla               A-channel request, one every cycle, never stalled
//   bus_tld               registered D-channel response, one cycle after the request
//   periph_valid/ready    valid/ready handshake presenting the FIFO head
//   periph_addr/data/mask payload of the FIFO head (zero when empty)
package pinwheel_tl_pkg;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_size;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_size;
        logic        d_denied;
        logic [31:0] d_data;
    } tilelink_d;
endpackage

module pinwheel_bus_port
    import pinwheel_tl_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  tilelink_a   bus_tla,
    output tilelink_d   bus_tld,
    output logic        periph_valid,
    output logic [7:0]  periph_addr,
    output logic [31:0] periph_data,
    output logic [3:0]  periph_mask,
    input  logic        periph_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [43:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_n;
    logic [15:0]   drop_count;
    logic [3:0]    tag;
    logic [AW-1:0] ram_idx;
    logic          get, put, is_ram, is_per, is_reg;
    logic          full, push, drop, pop;
    logic [31:0]   status, per_rd, rdata;

    assign tag     = bus_tla.a_address[31:28];
    assign ram_idx = bus_tla.a_address[AW+1:2];
    assign get     = bus_tla.a_valid && bus_tla.a_opcode == TL_GET;
    assign put     = bus_tla.a_valid && bus_tla.a_opcode == TL_PUT_PARTIAL;
    assign is_ram  = tag == 4'h8;
    assign is_per  = tag == 4'h4;
    assign is_reg  = tag == 4'hE;

    // Full is judged on the pre-edge count so a same-cycle pop never makes room.
    assign full    = count == (PW+1)'(FIFO_DEPTH);
    assign push    = put && is_per && !full;
    assign drop    = put && is_per && full;
    assign pop     = periph_valid && periph_ready;
    assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);

    // Status reflects the pop committing on the same edge that samples the read.
    assign status  = {16'b0, 8'(count_n), 6'b0, count_n == (PW+1)'(FIFO_DEPTH), count_n == '0};
    assign per_rd  = bus_tla.a_address[27:0] == 28'h0 ? status :
                     bus_tla.a_address[27:0] == 28'h4 ? {16'b0, drop_count} : 32'b0;
    assign rdata   = is_ram ? ram[ram_idx] : is_per ? per_rd : 32'b0;

    // Payload is gated by empty so the outputs read zero while in reset.
    assign periph_valid = count != '0;
    assign {periph_addr, periph_data, periph_mask} = periph_valid ? fifo[rd_ptr] : 44'b0;

    always_ff @(posedge clock) begin
        if (put && is_ram)
            for (int b = 0; b < 4; b++)
                if (bus_tla.a_mask[b]) ram[ram_idx][8*b +: 8] <= bus_tla.a_data[8*b +: 8];
        if (push) fifo[wr_ptr] <= {bus_tla.a_address[7:0], bus_tla.a_data, bus_tla.a_mask};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            bus_tld    <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            count      <= count_n;
            drop_count <= drop && drop_count != 16'hFFFF ? drop_count + 16'd1 : drop_count;
            bus_tld    <= '{d_valid:  1'b1,
                            d_opcode: get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK,
                            d_size:   bus_tla.a_size,
                            d_denied: !(is_ram || is_per || is_reg),
                            d_data:   get ? rdata : 32'b0};
        end
    end
endmodule

// File: tb/tb_pinwheel_bus_port.sv
// tb_pinwheel_bus_port: randomized self-checking bench for pinwheel_bus_port against a queue-based model
module tb_pinwheel_bus_port;
    import pinwheel_tl_pkg::*;
    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    tilelink_a   bus_tla;
    tilelink_d   bus_tld;
    logic        periph_valid;
    logic [7:0]  periph_addr;
    logic [31:0] periph_data;
    logic [3:0]  periph_mask;
    logic        periph_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mram [RAM_WORDS];
    logic [43:0] q [$];
    int unsigned mdrop = 0;

    pinwheel_bus_port #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .bus_tla(bus_tla), .bus_tld(bus_tld),
        .periph_valid(periph_valid), .periph_addr(periph_addr), .periph_data(periph_data),
        .periph_mask(periph_mask), .periph_ready(periph_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request cycle: drive, check the head presented before the edge, advance the model, check the response.
    task automatic cycle(input logic is_get, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic ready);
        tilelink_d   exp;
        logic [3:0]  tag = addr[31:28];
        logic [2:0]  sz = 3'($urandom_range(0, 2));
        int          w = int'((addr >> 2) % RAM_WORDS);
        logic        full_before;
        logic [31:0] rd = 32'b0;
        bus_tla = '{a_valid: 1'b1, a_opcode: is_get ? TL_GET : TL_PUT_PARTIAL, a_size: sz,
                    a_address: addr, a_mask: mask, a_data: data};
        periph_ready = ready;
        #1;
        check("periph_head", {periph_valid, periph_addr, periph_data, periph_mask},
              q.size() != 0 ? {1'b1, q[0]} : 45'd0);
        full_before = q.size() == FIFO_DEPTH;
        if (ready && q.size() != 0) q.delete(0);
        if (is_get) begin
            if (tag == 4'h8) rd = mram[w];
            else if (tag == 4'h4)
                rd = addr[27:0] == 0 ? {16'b0, 8'(q.size()), 6'b0, q.size() == FIFO_DEPTH, q.size() == 0} :
                     addr[27:0] == 4 ? mdrop : 32'b0;
        end else if (tag == 4'h8) begin
            for (int b = 0; b < 4; b++) if (mask[b]) mram[w][8*b +: 8] = data[8*b +: 8];
        end else if (tag == 4'h4) begin
            if (full_before) mdrop = mdrop < 32'hFFFF ? mdrop + 1 : mdrop;
            else q.push_back({addr[7:0], data, mask});
        end
        exp = '{d_valid: 1'b1, d_opcode: is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK, d_size: sz,
                d_denied: !(tag inside {4'h8, 4'h4, 4'hE}), d_data: rd};
        @(posedge clock);
        #1;
        check("tld", bus_tld, exp);
    endtask

    initial begin
        logic [3:0]  t;
        logic [31:0] a;
        reset_n = 1'b0;
        bus_tla = '0;
        periph_ready = 1'b0;
        #12;
        check("reset_tld", bus_tld, 40'd0);
        check("reset_periph", {periph_valid, periph_addr, periph_data, periph_mask}, 45'd0);
        reset_n = 1'b1;

        for (int i = 0; i < RAM_WORDS; i++) cycle(0, 32'h8000_0000 | (i << 2), $urandom, 4'hF, 0);

        cycle(0, 32'h8000_0010, 32'hAABB_CCDD, 4'b1111, 0);
        cycle(0, 32'h8000_0010, 32'h0000_0011, 4'b0001, 0);
        cycle(1, 32'h8000_0010, 0, 0, 0);
        check("byte_merge", bus_tld.d_data, 32'hAABB_CC11);
        check("byte_merge_op", bus_tld.d_opcode, TL_ACCESS_ACK_DATA);
        cycle(0, 32'h8000_0014, 32'hFFFF_FFFF, 4'b0000, 0);
        cycle(1, 32'h8000_0014, 0, 0, 0);

        cycle(0, 32'h8000_1000, 32'h1234_5678, 4'hF, 0);
        cycle(1, 32'h8000_0000, 0, 0, 0);
        check("ram_wrap", bus_tld.d_data, 32'h1234_5678);

        for (int i = 0; i < 10; i++) cycle(0, 32'h4000_0000 | i, $urandom, 4'($urandom), 0);
        cycle(1, 32'h4000_0000, 0, 0, 0);
        check("fill_status", bus_tld.d_data, 32'h0000_0802);
        cycle(1, 32'h4000_0004, 0, 0, 0);
        check("fill_drops", bus_tld.d_data, 32'd2);

        for (int i = 0; i < 100 && q.size() != 0; i++) cycle(1, 32'h4000_0000, 0, 0, 1'($urandom));
        cycle(1, 32'h4000_0000, 0, 0, 1);
        check("drained_status", bus_tld.d_data, 32'h0000_0001);

        for (int i = 0; i < 3; i++) cycle(0, 32'h4000_0020, $urandom, 4'hF, 0);
        cycle(0, 32'h4000_0024, $urandom, 4'hA, 1);
        cycle(1, 32'h4000_0000, 0, 0, 0);
        check("push_pop_count3", bus_tld.d_data, 32'h0000_0300);
        for (int i = 0; i < 5; i++) cycle(0, 32'h4000_0030, $urandom, 4'h5, 0);
        cycle(0, 32'h4000_0034, $urandom, 4'h3, 1);
        cycle(1, 32'h4000_0000, 0, 0, 0);
        check("push_pop_full", bus_tld.d_data, 32'h0000_0700);
        cycle(1, 32'h4000_0004, 0, 0, 0);
        check("full_drop_inc", bus_tld.d_data, 32'd3);

        cycle(1, 32'h4000_0000, 0, 0, 1);
        cycle(1, 32'h4000_0000, 0, 0, 1);
        reset_n = 1'b0;
        #1;
        check("async_periph_valid", periph_valid, 1'b0);
        check("async_d_valid", bus_tld.d_valid, 1'b0);
        check("async_tld", bus_tld, 40'd0);
        #1;
        reset_n = 1'b1;
        q.delete();
        mdrop = 0;
        cycle(1, 32'h4000_0000, 0, 0, 0);
        check("post_reset_status", bus_tld.d_data, 32'h0000_0001);
        cycle(1, 32'h4000_0004, 0, 0, 0);
        check("post_reset_drops", bus_tld.d_data, 32'd0);
        cycle(1, 32'h8000_0010, 0, 0, 0);
        check("ram_preserved", bus_tld.d_data, 32'hAABB_CC11);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: t = 4'h8;
                4, 5, 6:    t = 4'h4;
                7:          t = 4'hE;
                default:    do t = 4'($urandom); while (t inside {4'h8, 4'h4, 4'hE});
            endcase
            a = {t, 28'($urandom)};
            if (t == 4'h4 && $urandom_range(0, 2) != 0) a[27:0] = $urandom_range(0, 1) ? 28'h0 : 28'h4;
            cycle(1'($urandom), a, $urandom, 4'($urandom),
                  $urandom_range(0, 9) < (i < 1500 ? 1 : 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pinwheel_bus_port.md
# pinwheel_bus_port

Data-bus slave that sits directly downstream of the pinwheel core's data TileLink A channel and produces the D-channel response the core consumes in its next pipeline phase. It decodes the address tag, serves a byte-maskable data RAM with single-cycle latency, and posts peripheral stores into a FIFO. The FIFO drains to an external peripheral through a valid/ready handshake. The core never stalls, so every request is accepted and answered on the following cycle.

## Interface

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8, peripheral write FIFO depth; power of two, at least 2.

Ports:
- clock  in  1  Single clock; all state is updated on the rising edge.
- reset_n  in  1  Reset, asynchronous and active-low.
- bus_tla  in  tilelink_a  Request from the core. a_valid is always 1. a_opcode is Get or PutPartialData.
- bus_tld  out  tilelink_d  Registered response, returned one cycle after the request.
- periph_valid  out  1  The FIFO head is presented to the peripheral.
- periph_addr  out  8  a_address[7:0] of the FIFO head.
- periph_data  out  32  a_data of the FIFO head.
- periph_mask  out  4  a_mask of the FIFO head.
- periph_ready  in  1  The peripheral accepts the head this cycle.

## Operation

Address decode uses tag = a_address[31:28]:
- **0x8 (RAM):** word index = a_address[log2(RAM_WORDS)+1:2]. Upper offset bits are ignored, so accesses wrap.
  - Get reads the full word.
  - PutPartialData writes only the bytes enabled by a_mask. a_mask = 0 writes nothing.
- **0x4 (peripheral window):**
  - PutPartialData to any offset pushes {addr[7:0], data, mask} into the FIFO.
  - Get at offset 0x0 returns status = {16'b0, 8'(count), 6'b0, full, empty}.
  - Get at offset 0x4 returns drop_count, a 16-bit count zero-extended.
  - A Get at any other offset returns 0.
- **0xE (regfile, serviced inside the core):** Get returns 0 and Put has no effect. d_denied = 0.
- **All other tags:** Get returns 0 and Put is discarded. d_denied = 1 in the response.

Get has no side effects. The core issues Get every cycle it is not storing.

FIFO:
- Push on a peripheral Put when not full.
- A Put while full is dropped. drop_count increments and saturates at 0xFFFF. The FIFO is not modified.
- Pop when periph_valid && periph_ready.
- Push and pop in the same cycle: count is unchanged. When full, a same-cycle pop does NOT make room; the Put is dropped. This keeps the full decision independent of periph_ready.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- periph_valid = !empty.
- periph_addr, periph_data and periph_mask are the head entry. They must hold stable while periph_valid && !periph_ready.

Response fields:
- d_opcode = AccessAckData for Get and AccessAck for Put.
- d_data = read data, or 0 for Put.
- d_size echoes a_size.
- d_valid = 1 from the first edge after reset deassertion.

## Timing

- Request sampled at edge N; bus_tld is valid from edge N until edge N+1. Latency is exactly 1 cycle and there is no backpressure.
- RAM is read-during-write old-data: a Get and a Put are never simultaneous. A Get at N+1 to an address Put at N returns the new data.
- A status read reflects all pushes and pops committed at or before the edge that samples the read.
- Reset values while reset_n = 0, applied asynchronously:
  - bus_tld all fields 0, including d_valid = 0.
  - periph_valid = 0; periph_addr, periph_data and periph_mask = 0.
  - FIFO pointers, count and drop_count = 0.
- RAM contents are not reset.
- Reset asserted mid-drain: the FIFO head is discarded, and periph_valid falls immediately (combinationally from reset).
- Reset deassertion is synchronized by the integrator. The block needs no synchronizer.

## Test plan

- RAM byte write: Put 0x80000010 data 0xAABBCCDD mask 1111, then Put the same address data 0x00000011 mask 0001, then Get -> d_data 0xAABBCC11 one cycle after the Get, opcode AccessAckData.
- RAM wrap: with RAM_WORDS = 1024, Put 0x80001000 data 0x12345678, then Get 0x80000000 -> 0x12345678.
- FIFO fill and overflow: periph_ready = 0, 10 Puts to 0x40000000 with FIFO_DEPTH = 8 -> status Get returns 0x00000802 (count 8, full). Get 0x40000004 -> 2.
- Drain order: after the fill above, hold periph_ready = 1 -> 8 beats in push order with payloads stable while stalled, then periph_valid = 0 and status = 0x00000001.
- Simultaneous events:
  - Count 3 with push and pop in the same cycle -> count stays 3.
  - Full with push and pop in the same cycle -> drop_count +1, count 7.
- Async reset mid-operation: with FIFO count 5 and bus_tld valid, pulse reset_n low between edges -> periph_valid and d_valid drop immediately, status after release = 0x00000001, drop_count = 0, RAM data preserved.
